// File: rtl/mmu_arb_pkg.sv
// Shared types and helpers for the data-memory request arbiter: FSM states,
// queued request layout, func3 codes, byte-enable/lane and alignment decode.
package mmu_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  func3;
    logic [4:0]  rd;
  } dq_entry_t;

  localparam logic [2:0] FUNC3_LB  = 3'b000;
  localparam logic [2:0] FUNC3_LH  = 3'b001;
  localparam logic [2:0] FUNC3_LW  = 3'b010;
  localparam logic [2:0] FUNC3_LBU = 3'b100;
  localparam logic [2:0] FUNC3_LHU = 3'b101;
  localparam logic [2:0] FUNC3_SB  = 3'b000;
  localparam logic [2:0] FUNC3_SH  = 3'b001;
  localparam logic [2:0] FUNC3_SW  = 3'b010;

  // size is func3[1:0]: 00 byte, 01 half, otherwise full word
  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   be_gen = 4'b0001 << off;
      2'b01:   be_gen = 4'b0011 << {off[1], 1'b0};
      default: be_gen = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_rep(input logic [1:0] size, input logic [31:0] data);
    case (size)
      2'b00:   wdata_rep = {4{data[7:0]}};
      2'b01:   wdata_rep = {2{data[15:0]}};
      default: wdata_rep = data;
    endcase
  endfunction

  // Reserved encodings are reported as misaligned so they never reach memory
  function automatic logic misalign(input logic we, input logic [2:0] func3, input logic [1:0] off);
    logic bad_code;
    if (we) bad_code = !(func3 inside {FUNC3_SB, FUNC3_SH, FUNC3_SW});
    else    bad_code = !(func3 inside {FUNC3_LB, FUNC3_LH, FUNC3_LW, FUNC3_LBU, FUNC3_LHU});
    case (func3[1:0])
      2'b01:   misalign = bad_code | off[0];
      2'b10:   misalign = bad_code | (off != 2'b00);
      default: misalign = bad_code;
    endcase
  endfunction

endpackage

// File: rtl/mmu_req_arbiter_dq_fifo.sv
// Data-request queue: up to two pushes per cycle (port a ahead of port b),
// one pop. Pushes that find no room are dropped without disturbing contents.
module mmu_dq_fifo
  import mmu_arb_pkg::*;
#(
  parameter int DQ_DEPTH = 4
) (
  input  logic                        cpu_clk_aon,
  input  logic                        i_rstn,
  input  logic                        push_a,
  input  dq_entry_t                   din_a,
  input  logic                        push_b,
  input  dq_entry_t                   din_b,
  input  logic                        pop,
  output dq_entry_t                   head,
  output logic [$clog2(DQ_DEPTH):0]   count,
  output logic                        full,
  output logic                        empty
);

  localparam int PW = $clog2(DQ_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(DQ_DEPTH);
  localparam logic [CW-1:0] FULL_TH_C = CW'(DQ_DEPTH - 1);

  dq_entry_t mem [DQ_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, idx_b;
  logic [CW-1:0] count_q, count_d;
  logic          acc_a, acc_b, pop_ok;

  always_comb begin
    acc_a    = push_a && (count_q < DEPTH_C);
    acc_b    = push_b && ((count_q + CW'(acc_a)) < DEPTH_C);
    pop_ok   = pop && (count_q != '0);
    idx_b    = wr_ptr_q + PW'(acc_a);
    wr_ptr_d = wr_ptr_q + PW'(acc_a) + PW'(acc_b);
    rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    count_d  = count_q + CW'(acc_a) + CW'(acc_b) - CW'(pop_ok);
  end

  always_ff @(posedge cpu_clk_aon or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge cpu_clk_aon) begin
    if (acc_a) mem[wr_ptr_q] <= din_a;
    if (acc_b) mem[idx_b]    <= din_b;
  end

  assign head  = mem[rd_ptr_q];
  assign count = count_q;
  // Decode may still issue a rd+wr pair in the same cycle, so two slots are reserved
  assign full  = (count_q >= FULL_TH_C);
  assign empty = (count_q == '0);

endmodule

// File: rtl/mmu_req_arbiter.sv
// Arbitrates fetch against queued decode loads/stores onto one memory port.
// Define MMU_ARB_RR_EN for round-robin; otherwise the data queue has priority.
module mmu_req_arbiter
  import mmu_arb_pkg::*;
#(
  parameter int DQ_DEPTH = 4,
  parameter int AW       = 32
) (
  input  logic          cpu_clk_aon,
  input  logic          i_rstn,
  input  logic          if_req,
  input  logic [31:0]   if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [31:0]   if_rdata,
  input  logic          mmu_rd_req,
  input  logic [31:0]   mmu_rd_addr,
  input  logic [4:0]    mmu_rd_req_reg,
  input  logic [2:0]    mmu_rd_req_func3,
  input  logic          mmu_wr_req,
  input  logic [31:0]   mmu_wr_addr,
  input  logic [31:0]   mmu_wr_data,
  input  logic [2:0]    mmu_wr_req_func3,
  output logic          mmu_rd_valid,
  output logic [31:0]   mmu_rd_data,
  output logic [4:0]    mmu_rd_valid_reg,
  output logic [2:0]    mmu_rd_valid_func3,
  output logic          mmu_wr_done,
  output logic          dq_full,
  output logic          misalign,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    mem_be,
  input  logic          mem_gnt,
  input  logic          mem_rvalid,
  input  logic [31:0]   mem_rdata
);

  localparam int CW = $clog2(DQ_DEPTH) + 1;

  dq_entry_t     rd_entry, wr_entry, head;
  logic          dq_empty, dq_pop, head_mis, pick_fetch, pick_data;
  logic [CW-1:0] dq_count;
  logic          unused_bits;

  assign rd_entry = '{we: 1'b0, addr: mmu_rd_addr, wdata: 32'h0,
                      func3: mmu_rd_req_func3, rd: mmu_rd_req_reg};
  assign wr_entry = '{we: 1'b1, addr: mmu_wr_addr, wdata: mmu_wr_data,
                      func3: mmu_wr_req_func3, rd: 5'd0};
  assign unused_bits = ^{if_addr[1:0], dq_count};

  mmu_dq_fifo #(.DQ_DEPTH(DQ_DEPTH)) u_dq (
    .cpu_clk_aon (cpu_clk_aon),
    .i_rstn      (i_rstn),
    .push_a      (mmu_rd_req),
    .din_a       (rd_entry),
    .push_b      (mmu_wr_req),
    .din_b       (wr_entry),
    .pop         (dq_pop),
    .head        (head),
    .count       (dq_count),
    .full        (dq_full),
    .empty       (dq_empty)
  );

  arb_state_e    state_q, state_d;
  logic          sel_fetch_q, sel_fetch_d;
  logic          cur_we_q, cur_we_d;
  logic [1:0]    cur_off_q, cur_off_d;
  logic [2:0]    cur_func3_q, cur_func3_d;
  logic [4:0]    cur_rd_q, cur_rd_d;
  logic          mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]    mem_be_q, mem_be_d;
  logic          if_gnt_q, if_gnt_d, if_rvalid_q, if_rvalid_d;
  logic [31:0]   if_rdata_q, if_rdata_d;
  logic          rd_valid_q, rd_valid_d, wr_done_q, wr_done_d, mis_q, mis_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic [4:0]    rd_reg_q, rd_reg_d;
  logic [2:0]    rd_func3_q, rd_func3_d;
`ifdef MMU_ARB_RR_EN
  logic          ptr_fetch_q, ptr_fetch_d;
`endif

  assign head_mis = mmu_arb_pkg::misalign(head.we, head.func3, head.addr[1:0]);

`ifdef MMU_ARB_RR_EN
  assign pick_fetch = if_req && (dq_empty || ptr_fetch_q);
`else
  assign pick_fetch = if_req && dq_empty;
`endif
  assign pick_data  = !dq_empty && !pick_fetch;

  always_comb begin
    state_d     = state_q;
    sel_fetch_d = sel_fetch_q;
    cur_we_d    = cur_we_q;
    cur_off_d   = cur_off_q;
    cur_func3_d = cur_func3_q;
    cur_rd_d    = cur_rd_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    rd_valid_d  = 1'b0;
    wr_done_d   = 1'b0;
    mis_d       = 1'b0;
    rd_data_d   = rd_data_q;
    rd_reg_d    = rd_reg_q;
    rd_func3_d  = rd_func3_q;
    dq_pop      = 1'b0;
`ifdef MMU_ARB_RR_EN
    ptr_fetch_d = ptr_fetch_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_data) begin
`ifdef MMU_ARB_RR_EN
          ptr_fetch_d = 1'b1;
`endif
          if (head_mis) begin
            // Complete the request without touching memory so the pending-register scoreboard drains
            dq_pop  = 1'b1;
            mis_d   = 1'b1;
            state_d = RESP;
            if (head.we) begin
              wr_done_d = 1'b1;
            end else begin
              rd_valid_d = 1'b1;
              rd_data_d  = 32'h0;
              rd_reg_d   = head.rd;
              rd_func3_d = head.func3;
            end
          end else begin
            state_d     = ISSUE;
            sel_fetch_d = 1'b0;
            cur_we_d    = head.we;
            cur_off_d   = head.addr[1:0];
            cur_func3_d = head.func3;
            cur_rd_d    = head.rd;
            mem_req_d   = 1'b1;
            mem_we_d    = head.we;
            mem_addr_d  = {head.addr[AW-1:2], 2'b00};
            mem_wdata_d = head.we ? wdata_rep(head.func3[1:0], head.wdata) : 32'h0;
            mem_be_d    = be_gen(head.func3[1:0], head.addr[1:0]);
          end
        end else if (pick_fetch) begin
`ifdef MMU_ARB_RR_EN
          ptr_fetch_d = 1'b0;
`endif
          state_d     = ISSUE;
          sel_fetch_d = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {if_addr[AW-1:2], 2'b00};
          mem_wdata_d = 32'h0;
          mem_be_d    = 4'b1111;
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          state_d   = WAIT;
          mem_req_d = 1'b0;
          if (sel_fetch_q) if_gnt_d = 1'b1;
          else             dq_pop   = 1'b1;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_d = RESP;
          if (sel_fetch_q) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end else if (cur_we_q) begin
            wr_done_d = 1'b1;
          end else begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem_rdata >> {cur_off_q, 3'b000};
            rd_reg_d   = cur_rd_q;
            rd_func3_d = cur_func3_q;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk_aon or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q     <= IDLE;
      sel_fetch_q <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_gnt_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      rd_valid_q  <= 1'b0;
      wr_done_q   <= 1'b0;
      mis_q       <= 1'b0;
      rd_data_q   <= '0;
      rd_reg_q    <= '0;
      rd_func3_q  <= '0;
`ifdef MMU_ARB_RR_EN
      ptr_fetch_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sel_fetch_q <= sel_fetch_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_gnt_q    <= if_gnt_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      rd_valid_q  <= rd_valid_d;
      wr_done_q   <= wr_done_d;
      mis_q       <= mis_d;
      rd_data_q   <= rd_data_d;
      rd_reg_q    <= rd_reg_d;
      rd_func3_q  <= rd_func3_d;
`ifdef MMU_ARB_RR_EN
      ptr_fetch_q <= ptr_fetch_d;
`endif
    end
  end

  always_ff @(posedge cpu_clk_aon) begin
    cur_we_q    <= cur_we_d;
    cur_off_q   <= cur_off_d;
    cur_func3_q <= cur_func3_d;
    cur_rd_q    <= cur_rd_d;
  end

  assign mem_req            = mem_req_q;
  assign mem_we             = mem_we_q;
  assign mem_addr           = mem_addr_q;
  assign mem_wdata          = mem_wdata_q;
  assign mem_be             = mem_be_q;
  assign if_gnt             = if_gnt_q;
  assign if_rvalid          = if_rvalid_q;
  assign if_rdata           = if_rdata_q;
  assign mmu_rd_valid       = rd_valid_q;
  assign mmu_rd_data        = rd_data_q;
  assign mmu_rd_valid_reg   = rd_reg_q;
  assign mmu_rd_valid_func3 = rd_func3_q;
  assign mmu_wr_done        = wr_done_q;
  assign misalign           = mis_q;

endmodule
